// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 8x8 matrix controller: register
// addresses, controller state encoding, frame word layout and helpers.
package max7219_pkg;

    // MAX7219 register addresses
    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    localparam int NUM_ROWS    = 8;
    localparam int INIT_FRAMES = 6;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_REFRESH  = 3'd1,
        ST_IDLE     = 3'd2,
        ST_SEND_ROW = 3'd3,
        ST_SEND_INT = 3'd4
    } state_e;

    // 16-bit word shifted MSB first: upper nibble is don't-care, sent as 0
    typedef struct packed {
        logic [3:0] rsvd;
        logic [3:0] addr;
        logic [7:0] data;
    } frame_t;

    function automatic frame_t mk_frame(input logic [3:0] a, input logic [7:0] d);
        frame_t f;
        f.rsvd = 4'h0;
        f.addr = a;
        f.data = d;
        return f;
    endfunction

    // Power-up sequence: shutdown, test off, no decode, scan all 8, intensity, wake
    function automatic frame_t init_frame(input logic [2:0] idx, input logic [3:0] inten);
        frame_t f;
        case (idx)
            3'd0:    f = mk_frame(ADDR_SHUTDOWN, 8'h00);
            3'd1:    f = mk_frame(ADDR_TEST, 8'h00);
            3'd2:    f = mk_frame(ADDR_DECODE, 8'h00);
            3'd3:    f = mk_frame(ADDR_SCANLIM, 8'h07);
            3'd4:    f = mk_frame(ADDR_INTENSITY, {4'h0, inten});
            default: f = mk_frame(ADDR_SHUTDOWN, 8'h01);
        endcase
        return f;
    endfunction

    // Index of the lowest set bit (0 when none set; caller checks |v)
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/max7219_spi_tx.sv
// Frame serializer: shifts one 16-bit word MSB first. Each bit is held
// CLK_DIV cycles with sclk low then CLK_DIV cycles with sclk high; two
// trailing cycles with sclk low precede the cs_n rise, then cs_n stays
// high at least CLK_DIV cycles before the next frame may start.
module max7219_spi_tx
    import max7219_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  frame_t frame,
    output logic   ready,
    output logic   done,
    output logic   busy,
    output logic   sclk,
    output logic   mosi,
    output logic   cs_n
);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_SHIFT = 2'd1;
    localparam logic [1:0] TX_TAIL  = 2'd2;
    localparam logic [1:0] TX_GAP   = 2'd3;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    logic [1:0]  r_state;
    logic [15:0] r_shift;
    logic [3:0]  r_bit;
    logic [7:0]  r_cnt;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_cs_n;
    logic        r_done;
    logic [15:0] w_frame_bits;

    assign w_frame_bits = frame;

    // Bit-timing state machine; all pin outputs are registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_cnt   <= '0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (start) begin
                        r_shift <= w_frame_bits;
                        r_mosi  <= w_frame_bits[15];
                        r_cs_n  <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_bit   <= 4'd15;
                        r_cnt   <= '0;
                        r_state <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (r_cnt == DIV_M1) begin
                        r_cnt <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit == 4'd0) begin
                                r_state <= TX_TAIL;
                            end else begin
                                r_bit  <= r_bit - 4'd1;
                                r_mosi <= r_shift[r_bit - 4'd1];
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                TX_TAIL: begin
                    // sclk already low; hold cs_n two more cycles, then latch
                    if (r_cnt == 8'd1) begin
                        r_cs_n  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= TX_GAP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    if (r_cnt == DIV_M1) begin
                        r_cnt   <= '0;
                        r_state <= TX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    assign ready = (r_state == TX_IDLE);
    // busy covers the low phase of cs_n plus the cycle in which it rises
    assign busy  = (r_state == TX_SHIFT) || (r_state == TX_TAIL) || r_done;
    assign done  = r_done;
    assign sclk  = r_sclk;
    assign mosi  = r_mosi;
    assign cs_n  = r_cs_n;

endmodule

// File: rtl/max7219_ctrl.sv
// MAX7219 8x8 matrix controller: power-up init, full refresh, then
// incremental updates of dirty framebuffer rows and intensity changes.
module max7219_ctrl
    import max7219_pkg::*;
#(
    parameter int         CLK_DIV   = 25,
    parameter logic [3:0] INTENSITY = 4'h8
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       int_valid,
    input  logic [3:0] int_level,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic       init_done,
    output logic       busy
);

    state_e          r_state;
    logic [2:0]      r_idx;
    logic [7:0][7:0] r_fb;
    logic [7:0]      r_dirty;
    logic            r_int_pending;
    logic [3:0]      r_int_level;
    logic            r_init_done;

    state_e     w_state_nxt;
    logic [2:0] w_idx_nxt;
    logic       w_start;
    frame_t     w_frame;
    logic [7:0] w_dirty_clr;
    logic       w_int_clr;
    logic       w_refresh_start;
    logic       w_init_done_set;
    logic       w_wr;
    logic [7:0] w_dirty_set;
    logic [2:0] w_row_sel;
    logic       w_tx_ready;
    logic       w_tx_done;

    // Host writes are accepted unconditionally whenever out of reset
    assign wr_ready    = ~reset_reset;
    assign w_wr        = wr_valid & wr_ready;
    assign w_dirty_set = w_wr ? (8'b1 << wr_row) : 8'h00;
    assign w_row_sel   = lowest_set(r_dirty);

    // Sequencing and arbitration; a frame launches only when the serializer is idle
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_start         = 1'b0;
        w_frame         = mk_frame(ADDR_NOOP, 8'h00);
        w_dirty_clr     = 8'h00;
        w_int_clr       = 1'b0;
        w_refresh_start = 1'b0;
        w_init_done_set = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (w_tx_ready) begin
                    w_start = 1'b1;
                    w_frame = init_frame(r_idx, INTENSITY);
                end
                if (w_tx_done) begin
                    if (r_idx == 3'(INIT_FRAMES - 1)) begin
                        w_idx_nxt       = 3'd0;
                        w_state_nxt     = ST_REFRESH;
                        w_refresh_start = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            ST_REFRESH: begin
                if (w_tx_ready) begin
                    w_start = 1'b1;
                    w_frame = mk_frame({1'b0, r_idx} + 4'd1, r_fb[r_idx]);
                end
                if (w_tx_done) begin
                    if (r_idx == 3'(NUM_ROWS - 1)) begin
                        w_idx_nxt       = 3'd0;
                        w_state_nxt     = ST_IDLE;
                        w_init_done_set = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (w_tx_ready) begin
                    if (r_int_pending) begin
                        w_start     = 1'b1;
                        w_frame     = mk_frame(ADDR_INTENSITY, {4'h0, r_int_level});
                        w_int_clr   = 1'b1;
                        w_state_nxt = ST_SEND_INT;
                    end else if (|r_dirty) begin
                        w_start     = 1'b1;
                        w_frame     = mk_frame({1'b0, w_row_sel} + 4'd1, r_fb[w_row_sel]);
                        w_dirty_clr = 8'b1 << w_row_sel;
                        w_state_nxt = ST_SEND_ROW;
                    end
                end
            end
            ST_SEND_ROW, ST_SEND_INT: begin
                if (w_tx_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Controller state, sequence index and init_done flag
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state     <= ST_INIT;
            r_idx       <= 3'd0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_init_done_set) r_init_done <= 1'b1;
        end
    end

    // Framebuffer and dirty map; a write in the same cycle as a clear wins
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_fb    <= '0;
            r_dirty <= 8'h00;
        end else begin
            if (w_wr) r_fb[wr_row] <= wr_data;
            if (w_refresh_start) r_dirty <= w_dirty_set;
            else                 r_dirty <= (r_dirty & ~w_dirty_clr) | w_dirty_set;
        end
    end

    // Intensity request latch; a new strobe overrides both level and clear
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_int_pending <= 1'b0;
            r_int_level   <= 4'h0;
        end else if (int_valid) begin
            r_int_pending <= 1'b1;
            r_int_level   <= int_level;
        end else if (w_int_clr) begin
            r_int_pending <= 1'b0;
        end
    end

    max7219_spi_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .start (w_start),
        .frame (w_frame),
        .ready (w_tx_ready),
        .done  (w_tx_done),
        .busy  (busy),
        .sclk  (spi_sclk),
        .mosi  (spi_mosi),
        .cs_n  (spi_cs_n)
    );

    assign init_done = r_init_done;

endmodule
